// File: rtl/ahb_pkg.sv
// Shared AHB-Lite master definitions:
// transfer/size encodings and the phase-register bundle.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } phase_t;

endpackage

// File: rtl/ahb_lane_unit.sv
// Byte-lane helper: alignment check, write replication, read extraction.
// Ports: cmd_size/cmd_lsb -> cmd_err, wr_* -> wr_lanes, rd_* -> rd_data.
import ahb_pkg::*;

module ahb_lane_unit (
  input  logic [1:0]  cmd_size,
  input  logic [1:0]  cmd_lsb,
  output logic        cmd_err,
  input  logic [1:0]  wr_size,
  input  logic [31:0] wr_data,
  output logic [31:0] wr_lanes,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_addr,
  input  logic [31:0] hrdata,
  output logic [31:0] rd_data
);

  always_comb begin
    cmd_err = 1'b1;
    unique case (1'b1)
      (cmd_size == HSIZE_BYTE[1:0]): cmd_err = 1'b0;
      (cmd_size == HSIZE_HALF[1:0]): cmd_err = cmd_lsb[0];
      (cmd_size == HSIZE_WORD[1:0]): cmd_err = |cmd_lsb;
      default:                       cmd_err = 1'b1;
    endcase
  end

  always_comb begin
    wr_lanes = wr_data;
    unique case (1'b1)
      (wr_size == HSIZE_BYTE[1:0]): wr_lanes = {4{wr_data[7:0]}};
      (wr_size == HSIZE_HALF[1:0]): wr_lanes = {2{wr_data[15:0]}};
      default:                      wr_lanes = wr_data;
    endcase
  end

  always_comb begin
    rd_data = hrdata;
    unique case (1'b1)
      (rd_size == HSIZE_BYTE[1:0]):
        rd_data = {24'h0, hrdata[{rd_addr, 3'b000} +: 8]};
      (rd_size == HSIZE_HALF[1:0]):
        rd_data = {16'h0, hrdata[{rd_addr[1], 4'b0000} +: 16]};
      default:
        rd_data = hrdata;
    endcase
  end

endmodule

// File: rtl/ahb_cmd_master.sv
// AHB-Lite master: valid/ready commands -> NONSEQ singles, in-order responses.
// Ports: HCLK/HRESETn, cmd_* stream in, rsp_* pulse out, AHB-Lite master bus.
import ahb_pkg::*;

module ahb_cmd_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY
);

  phase_t      ap;
  phase_t      dp;
  logic        acc_err;
  logic [31:0] wr_lanes;
  logic [31:0] rd_data;
  logic        unused_ok;

  assign cmd_ready = HREADY;
  // DP wdata already holds the replicated lanes, so it is the bus value.
  assign HWDATA    = dp.wdata;
  assign unused_ok = ^dp.addr[31:2];

  ahb_lane_unit u_lane (
    .cmd_size (cmd_size),
    .cmd_lsb  (cmd_addr[1:0]),
    .cmd_err  (acc_err),
    .wr_size  (ap.size),
    .wr_data  (ap.wdata),
    .wr_lanes (wr_lanes),
    .rd_size  (dp.size),
    .rd_addr  (dp.addr[1:0]),
    .hrdata   (HRDATA),
    .rd_data  (rd_data)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap        <= '0;
      dp        <= '0;
      HADDR     <= '0;
      HTRANS    <= HTRANS_IDLE;
      HWRITE    <= 1'b0;
      HSIZE     <= HSIZE_BYTE;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (HREADY) begin
      dp       <= ap;
      dp.wdata <= wr_lanes;
      ap.valid <= cmd_valid;
      ap.err   <= acc_err;
      ap.write <= cmd_write;
      ap.size  <= cmd_size;
      ap.addr  <= cmd_addr;
      ap.wdata <= cmd_wdata;
      // Misaligned commands ride the pipe as IDLE; the bus keeps its
      // last address-phase controls.
      if (cmd_valid && !acc_err) begin
        HTRANS <= HTRANS_NONSEQ;
        HADDR  <= cmd_addr;
        HWRITE <= cmd_write;
        HSIZE  <= {1'b0, cmd_size};
      end else begin
        HTRANS <= HTRANS_IDLE;
      end
      rsp_valid <= dp.valid;
      if (dp.valid) begin
        rsp_write <= dp.write;
        rsp_err   <= dp.err;
        rsp_rdata <= (dp.write || dp.err) ? 32'h0 : rd_data;
      end
    end else begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: memory slave with injectable waits,
// response scoreboard with latency checks.
module tb_ahb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE;

  always #5 HCLK = ~HCLK;

  ahb_cmd_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_size(cmd_size),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // Slave memory model
  logic [31:0] mem [16];
  logic        s_valid, s_write;
  logic [2:0]  s_size;
  logic [31:0] s_addr;
  logic [1:0]  wait_cnt;
  int          ns_cnt;
  int          stall_idx = 0;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw,
                                        logic [2:0] sz, logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (sz)
      3'd0:    r[{a, 3'b000} +: 8] = nw[{a, 3'b000} +: 8];
      3'd1:    r[{a[1], 4'b0000} +: 16] = nw[{a[1], 4'b0000} +: 16];
      default: r = nw;
    endcase
    return r;
  endfunction

  assign HREADY = (wait_cnt == 2'd0);
  assign HRDATA = (s_valid && !s_write) ? mem[s_addr[5:2]] : 32'h0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_valid  <= 1'b0;
      s_write  <= 1'b0;
      s_size   <= 3'd0;
      s_addr   <= '0;
      wait_cnt <= 2'd0;
      ns_cnt   <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (wait_cnt != 2'd0) begin
      wait_cnt <= wait_cnt - 2'd1;
    end else begin
      if (s_valid && s_write)
        mem[s_addr[5:2]] <= merge(mem[s_addr[5:2]], HWDATA, s_size, s_addr[1:0]);
      s_valid <= (HTRANS == 2'b10);
      s_write <= HWRITE;
      s_size  <= HSIZE;
      s_addr  <= HADDR;
      if (HTRANS == 2'b10) begin
        ns_cnt <= ns_cnt + 1;
        if (ns_cnt + 1 == stall_idx) wait_cnt <= 2'd3;
      end
    end
  end

  // Scoreboard
  typedef struct {
    logic        w;
    logic        e;
    logic [31:0] d;
    int          acc;
    int          extra;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   cyc = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(negedge HCLK) begin
    if (HRESETn && rsp_valid) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        me = q.pop_front();
        chk("rsp_write", 32'(rsp_write), 32'(me.w));
        chk("rsp_err", 32'(rsp_err), 32'(me.e));
        chk("rsp_rdata", rsp_rdata, me.d);
        chk("rsp_latency", 32'(cyc - me.acc), 32'(2 + me.extra));
      end
    end
  end

  // Stall monitor: bus frozen and cmd_ready low while HREADY is low
  logic        prev_stall = 1'b0;
  logic [31:0] sn_addr, sn_wd;
  logic [1:0]  sn_tr;
  int          stall_cycles = 0;

  always @(negedge HCLK) begin
    if (HRESETn && !HREADY) begin
      stall_cycles++;
      chk("stall_ready", 32'(cmd_ready), 32'd0);
      if (prev_stall) begin
        chk("stall_haddr", HADDR, sn_addr);
        chk("stall_htrans", 32'(HTRANS), 32'(sn_tr));
        chk("stall_hwdata", HWDATA, sn_wd);
      end else begin
        sn_addr = HADDR;
        sn_tr   = HTRANS;
        sn_wd   = HWDATA;
      end
      prev_stall = 1'b1;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(logic w, logic [1:0] sz, logic [31:0] a,
                      logic [31:0] wd, logic e, logic [31:0] d, int extra);
    exp_t x;
    int   n;
    @(negedge HCLK);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_size  = sz;
    cmd_addr  = a;
    cmd_wdata = wd;
    #1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge HCLK);
      #1;
      n++;
    end
    chk("accept", 32'(cmd_ready), 32'd1);
    x.w = w;
    x.e = e;
    x.d = d;
    x.acc = cyc + 1;
    x.extra = extra;
    q.push_back(x);
  endtask

  task automatic drain();
    @(negedge HCLK);
    cmd_valid = 1'b0;
    for (int n = 0; n < 30 && q.size() != 0; n++) @(posedge HCLK);
    #2;
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  logic [31:0] v [8];
  int          pre;

  initial begin
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_size  = 2'd0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);

    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_write", 32'(rsp_write), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Word write then read
    send(1'b1, 2'd2, 32'h0, 32'h44332211, 1'b0, 32'h0, 0);
    drain();
    send(1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 32'h44332211, 0);
    drain();

    // Sub-word accesses at 0x4
    send(1'b1, 2'd2, 32'h4, 32'h44332211, 1'b0, 32'h0, 0);
    send(1'b0, 2'd1, 32'h4, 32'h0, 1'b0, 32'h2211, 0);
    send(1'b0, 2'd0, 32'h7, 32'h0, 1'b0, 32'h44, 0);
    send(1'b0, 2'd1, 32'h6, 32'h0, 1'b0, 32'h4433, 0);
    send(1'b1, 2'd0, 32'h5, 32'h123456AB, 1'b0, 32'h0, 0);
    send(1'b0, 2'd2, 32'h4, 32'h0, 1'b0, 32'h4433AB11, 0);
    send(1'b1, 2'd1, 32'h6, 32'h9999BEEF, 1'b0, 32'h0, 0);
    send(1'b0, 2'd2, 32'h4, 32'h0, 1'b0, 32'hBEEFAB11, 0);
    send(1'b0, 2'd0, 32'h5, 32'h0, 1'b0, 32'hAB, 0);
    drain();

    // Back-to-back pipelined traffic
    for (int i = 0; i < 8; i++) v[i] = (32'(i) * 32'h01010101) ^ 32'hA5C30000;
    for (int i = 0; i < 8; i++)
      send(1'b1, 2'd2, 32'(i * 4), v[i], 1'b0, 32'h0, 0);
    for (int i = 0; i < 8; i++)
      send(1'b0, 2'd2, 32'(i * 4), 32'h0, 1'b0, v[i], 0);
    drain();

    // Misaligned commands keep order and never reach the bus
    pre = ns_cnt;
    send(1'b0, 2'd2, 32'h2, 32'h0, 1'b1, 32'h0, 0);
    send(1'b0, 2'd2, 32'h0, 32'h0, 1'b0, v[0], 0);
    send(1'b1, 2'd1, 32'h1, 32'hFFFF, 1'b1, 32'h0, 0);
    send(1'b0, 2'd3, 32'h0, 32'h0, 1'b1, 32'h0, 0);
    drain();
    chk("misalign_nonseq", 32'(ns_cnt - pre), 32'd1);

    // Wait states on the second transfer
    stall_cycles = 0;
    stall_idx = ns_cnt + 2;
    send(1'b1, 2'd2, 32'h20, 32'h11111111, 1'b0, 32'h0, 0);
    send(1'b1, 2'd2, 32'h24, 32'hCAFEF00D, 1'b0, 32'h0, 3);
    send(1'b0, 2'd2, 32'h24, 32'h0, 1'b0, 32'hCAFEF00D, 3);
    drain();
    chk("stall_cycles", 32'(stall_cycles), 32'd3);
    send(1'b0, 2'd2, 32'h20, 32'h0, 1'b0, 32'h11111111, 0);
    drain();

    // Reset during the data phase of a write
    send(1'b1, 2'd2, 32'h28, 32'h5555AAAA, 1'b0, 32'h0, 0);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    chk("midrst_htrans", 32'(HTRANS), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    q.delete();
    @(negedge HCLK);
    chk("midrst_htrans_hold", 32'(HTRANS), 32'd0);
    HRESETn = 1'b1;
    send(1'b1, 2'd2, 32'h28, 32'h600DF00D, 1'b0, 32'h0, 0);
    send(1'b0, 2'd2, 32'h28, 32'h0, 1'b0, 32'h600DF00D, 0);
    drain();

    repeat (3) @(negedge HCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
